// File: rtl/io_handshake.sv
// Purpose : operator Enter handshake -- synchronizes and debounces the Enter button,
//           arms on an I/O instruction, fires one Enter pulse per physical press.
// Latency : Enter rises one cycle after the debounced press edge; a raw press needs
//           2 sync cycles plus DEBOUNCE_CYCLES stable cycles to become that edge.
// Backpr. : none; the control unit holds outData until Enter, and dropping outData
//           while armed aborts the request without a pulse.
module io_handshake #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inData,
    input  logic        outData,
    input  logic        button_n,
    input  logic [15:0] switches,
    input  logic [31:0] wr_data,
    output logic        Enter,
    output logic [31:0] in_value,
    output logic [31:0] display,
    output logic        waiting
);

    // Terminal count of the debounce counter; the level flips on the cycle the
    // counter would otherwise reach DEBOUNCE_CYCLES.
    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Synchronizer flops; button is kept active-low all the way to the debouncer.
    logic        btn_meta_q;
    logic        btn_sync_q;
    logic [15:0] sw_meta_q;
    logic [15:0] sw_sync_q;

    // Debouncer state: db_lvl_q is the accepted level (1 = released).
    logic [19:0] db_cnt_q;
    logic [19:0] db_cnt_d;
    logic        db_lvl_q;
    logic        db_lvl_d;
    logic        press_q;
    logic        press_d;

    // Handshake FSM and registered outputs.
    state_t      state_q;
    state_t      state_d;
    logic        enter_q;
    logic [31:0] in_value_q;
    logic [31:0] in_value_d;
    logic [31:0] display_q;
    logic [31:0] display_d;

    // Two-flop synchronizers for the asynchronous button and switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= button_n;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Debounce: count consecutive cycles the synchronized button disagrees with the
    // accepted level; any agreement restarts the count, so glitches never accumulate.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        press_d  = 1'b0;
        if (btn_sync_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d = btn_sync_q;
                // Only the released-to-pressed transition is a press edge.
                press_d  = ~btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 20'd1;
            end
        end
    end

    // Debouncer registers; press_q is the one-cycle press edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
            press_q  <= press_d;
        end
    end

    // Next-state logic. Press edges are only consumed in ARMED, so an edge seen in
    // IDLE is lost and a button already held on arming cannot fire. HOLD waits for a
    // debounced release so a long press spans instructions without re-firing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (outData) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // outData dropping wins over a simultaneous press edge.
                if (!outData) begin
                    state_d = IDLE;
                end else if (press_q) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (db_lvl_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data path: in_value tracks the switches while armed and therefore freezes on
    // the edge into FIRE; display loads on the edge that ends FIRE for output-only
    // instructions.
    always_comb begin
        in_value_d = in_value_q;
        display_d  = display_q;
        if (state_q == ARMED) begin
            in_value_d = {16'b0, sw_sync_q};
        end
        if ((state_q == FIRE) && outData && !inData) begin
            display_d = wr_data;
        end
    end

    // State and output registers; Enter is a flop mirroring entry into FIRE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            enter_q    <= 1'b0;
            in_value_q <= '0;
            display_q  <= '0;
        end else begin
            state_q    <= state_d;
            enter_q    <= (state_d == FIRE);
            in_value_q <= in_value_d;
            display_q  <= display_d;
        end
    end

    assign Enter    = enter_q;
    assign in_value = in_value_q;
    assign display  = display_q;
    assign waiting  = (state_q == ARMED);

endmodule

// File: doc/io_handshake.md
IO_HANDSHAKE -- requirements
Module: io_handshake

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, sets the consecutive stable cycles a button level change needs before it is accepted (legal range 2 to 2^20-1).
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 inData  input  1  control-unit strobe: current instruction is input.
REQ-005 outData  input  1  control-unit strobe: current instruction is I/O (input, output, endProc) and needs operator confirmation.
REQ-006 button_n  input  1  raw Enter push-button; asynchronous, active-low, bouncing.
REQ-007 switches  input  16  raw operator data switches; asynchronous.
REQ-008 wr_data  input  32  register-file value to be shown by output instructions.
REQ-009 Enter  output  1  registered one-cycle confirmation pulse to the control unit.
REQ-010 in_value  output  32  zero-extended captured switch value, written back by input instructions.
REQ-011 display  output  32  display register.
REQ-012 waiting  output  1  high while the block is armed and waiting for a press.

Function
REQ-013 button_n and switches SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Debouncer: a 20-bit counter SHALL increment while the synchronized button differs from the debounced level, and SHALL clear when they match.
REQ-015 When the debounce counter reaches DEBOUNCE_CYCLES-1, the debounced level SHALL toggle and the counter SHALL clear in the same cycle.
REQ-016 press_edge SHALL be high for one cycle when the debounced level changes from released to pressed.
REQ-017 The FSM SHALL have four states: IDLE, ARMED, FIRE, HOLD.
REQ-018 IDLE -> ARMED when outData=1; otherwise the FSM stays in IDLE, and any press_edge in IDLE SHALL be discarded, not stored.
REQ-019 ARMED -> FIRE on press_edge while outData=1.
REQ-020 ARMED -> IDLE if outData=0, with no Enter pulse.
REQ-021 A button already held when the FSM enters ARMED SHALL NOT fire; it must first be released and then pressed again.
REQ-022 FIRE SHALL last exactly one cycle with Enter=1, then go unconditionally to HOLD.
REQ-023 Enter SHALL be 0 in every state except FIRE.
REQ-024 HOLD -> IDLE when the debounced level reads released, so one physical press yields at most one Enter pulse regardless of hold time.
REQ-025 waiting SHALL equal (state==ARMED).
REQ-026 in_value SHALL equal {16'b0, synchronized switches} on every clock while in ARMED.
REQ-027 in_value SHALL freeze on the edge into FIRE and hold until the next ARMED, so it is stable throughout the FIRE cycle.
REQ-028 display SHALL load wr_data on the clock edge that ends FIRE when outData=1 and inData=0; display SHALL hold its value otherwise.
REQ-029 If press_edge and outData falling occur in the same ARMED cycle, the FSM SHALL go to IDLE with no pulse.
REQ-030 Latency: Enter SHALL assert exactly one cycle after the cycle in which press_edge is high.

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE, Enter=0, waiting=0, in_value=0, display=0, debounce counter=0, debounced level=released, synchronizers=released/0.
REQ-032 Reset mid-operation (any state, including FIRE) SHALL abort immediately with no Enter pulse in the following cycle.
REQ-033 Reset SHALL take priority over all other inputs.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 outData=1, inData=1, switches=16'hA5C3, clean press held 10 cycles -> exactly one Enter pulse; in_value=32'h0000A5C3 during that pulse.
REQ-035 outData=1, inData=0, wr_data=32'hDEADBEEF, press -> one Enter pulse; display=32'hDEADBEEF on the following cycle.
REQ-036 Button bouncing with 2-cycle glitches for 20 cycles, then stable pressed -> no Enter until 4 stable cycles, then a single pulse.
REQ-037 Button held before outData rises -> no Enter; release then press -> one pulse.
REQ-038 Press held 100 cycles across two consecutive I/O instructions -> only one Enter pulse; second instruction waits for a fresh press.
REQ-039 reset asserted in ARMED, then released with button still pressed -> outputs at reset values; no Enter pulse until release and a re-press.
